// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a FIFO write port: IDLE/XFER FSM, one grant per burst.
// Define FIFO_WR_ARB_BURST_EN for bursts of up to burst_len words; otherwise every grant carries one word.
module fifo_wr_arbiter #(
  parameter int width     = 32,
  parameter int nreq      = 4,
  parameter int burst_len = 8
) (
  input  logic                    clk_w,
  input  logic                    rst_w,
  input  logic [nreq-1:0]         req,
  input  logic [nreq*width-1:0]   wdata_in,
  input  logic                    full,
  output logic                    wrt_enable,
  output logic [width-1:0]        wdata,
  output logic [nreq-1:0]         gnt,
  output logic [nreq-1:0]         ack,
  output logic                    busy
);

  localparam int IW = (nreq > 1) ? $clog2(nreq) : 1;

  if (nreq < 2 || nreq > 16 || burst_len < 1 || burst_len > 256) begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic [nreq-1:0] r_gnt;
  logic [IW-1:0]   w_win;
  logic            w_found;
  logic            w_xfer;
  logic            w_done;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int CW = $clog2(burst_len) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(burst_len - 1);
  logic [CW-1:0] r_cnt;
`endif

  // Round-robin search starting just above the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 1; k <= nreq; k++) begin
      int j;
      j = (int'(r_last) + k) % nreq;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_win   = IW'(j);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Write strobe, ack and data mux; all gated off while reset is asserted.
  always_comb begin
    w_xfer     = (r_state == XFER) && rst_w;
    wrt_enable = w_xfer && req[r_last] && !full;
    busy       = w_xfer;
    gnt        = r_gnt;
    if (wrt_enable) begin
      ack = r_gnt;
    end else begin
      ack = '0;
    end
    if ((r_gnt != '0) && rst_w) begin
      wdata = wdata_in[int'(r_last)*width +: width];
    end else begin
      wdata = '0;
    end
`ifdef FIFO_WR_ARB_BURST_EN
    w_done = wrt_enable && (r_cnt == LAST_CNT);
`else
    w_done = wrt_enable;
`endif
  end

  // Arbitration FSM; a stalled (full) cycle leaves grant and count untouched.
  always_ff @(posedge clk_w) begin
    if (!rst_w) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= IW'(nreq - 1);
`ifdef FIFO_WR_ARB_BURST_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= XFER;
            r_gnt   <= {{(nreq-1){1'b0}}, 1'b1} << w_win;
            r_last  <= w_win;
`ifdef FIFO_WR_ARB_BURST_EN
            r_cnt   <= '0;
`endif
          end
        end
        XFER: begin
          if (!req[r_last] || w_done) begin
            r_state <= IDLE;
            r_gnt   <= '0;
          end
`ifdef FIFO_WR_ARB_BURST_EN
          else if (wrt_enable) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios push expected writers, a negedge monitor pops and compares.
module tb_fifo_wr_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int BL = 8;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam int EBL = BL;
`else
  localparam int EBL = 1;
`endif

  logic           clk_w = 1'b0;
  logic           rst_w;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata_in;
  logic           full;
  logic           wrt_enable;
  logic [W-1:0]   wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int sb[$];

  fifo_wr_arbiter #(.width(W), .nreq(N), .burst_len(BL)) dut (
    .clk_w(clk_w), .rst_w(rst_w), .req(req), .wdata_in(wdata_in), .full(full),
    .wrt_enable(wrt_enable), .wdata(wdata), .gnt(gnt), .ack(ack), .busy(busy)
  );

  always #5 clk_w = ~clk_w;

  function automatic logic [W-1:0] dat(input int i);
    return {16'hC0DE, 8'(i), 8'h5A};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_w);
    #1;
  endtask

  task automatic push_n(input int who, input int n);
    for (int i = 0; i < n; i++) sb.push_back(who);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual=%0d expected=0 words outstanding", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk_w) begin
    if (wrt_enable === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual gnt=%0h expected no write", gnt);
      end else begin : pop_blk
        int e;
        logic [N-1:0] oh;
        e  = sb.pop_front();
        oh = 4'b0001 << e;
        chk("sb_ack", 64'(ack), 64'(oh));
        chk("sb_gnt", 64'(gnt), 64'(oh));
        chk("sb_wdata", 64'(wdata), 64'(dat(e)));
      end
    end else begin
      chk("idle_ack", 64'(ack), 64'h0);
    end
  end

  initial begin
    int order[5];
    int pre;
    int n1;
    order = '{0, 1, 2, 3, 0};
    rst_w = 1'b0;
    req   = '0;
    full  = 1'b0;
    for (int i = 0; i < N; i++) wdata_in[i*W +: W] = dat(i);

    // Reset, with requests present
    repeat (3) tick();
    req = 4'b1111;
    tick();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_we", 64'(wrt_enable), 64'h0);
    chk("rst_wdata", 64'(wdata), 64'h0);

    // Alternating grants 0,2,0,2
    rst_w = 1'b1;
    req   = 4'b0101;
    for (int k = 0; k < 4; k++) push_n((k % 2) ? 2 : 0, EBL);
    tick();
    chk("s1_gnt_latency", 64'(gnt), 64'h1);
    wait_empty("s1");
    req = 4'b0000;
    chk("s1_idle_busy", 64'(busy), 64'h0);

    // Single requester: full burst, one bubble, re-grant
    req = 4'b0100;
    push_n(2, EBL);
    tick();
    chk("s2_gnt", 64'(gnt), 64'h4);
    for (int i = 1; i < EBL; i++) begin
      tick();
      chk("s2_busy", 64'(busy), 64'h1);
    end
    tick();
    chk("s2_bubble_busy", 64'(busy), 64'h0);
    chk("s2_bubble_gnt", 64'(gnt), 64'h0);
    tick();
    chk("s2_regrant", 64'(gnt), 64'h4);
    req = 4'b0000;
    #1;
    chk("s2_drop_we", 64'(wrt_enable), 64'h0);
    tick();
    chk("s2_end_busy", 64'(busy), 64'h0);

    // Stall on full for 5 cycles after pre words
    pre = (EBL > 3) ? 3 : 0;
    req = 4'b0010;
    push_n(1, EBL);
    tick();
    chk("s3_gnt", 64'(gnt), 64'h2);
    repeat (pre) tick();
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      chk("s3_stall_we", 64'(wrt_enable), 64'h0);
      chk("s3_stall_gnt", 64'(gnt), 64'h2);
    end
    tick();
    full = 1'b0;
    wait_empty("s3");
    req = 4'b0000;
    chk("s3_end_busy", 64'(busy), 64'h0);

    // Request drops mid-burst, then counter restarts on next grant
    n1  = (EBL > 2) ? 2 : EBL;
    req = 4'b0010;
    push_n(1, n1);
    push_n(1, EBL);
    tick();
    chk("s4_gnt", 64'(gnt), 64'h2);
    repeat (n1) tick();
    req = 4'b0000;
    #1;
    chk("s4_drop_we", 64'(wrt_enable), 64'h0);
    tick();
    chk("s4_idle_busy", 64'(busy), 64'h0);
    chk("s4_idle_gnt", 64'(gnt), 64'h0);
    req = 4'b0010;
    tick();
    chk("s4_regrant", 64'(gnt), 64'h2);
    wait_empty("s4");
    req = 4'b0000;
    chk("s4_end_busy", 64'(busy), 64'h0);

    // Reset mid-burst aborts; requester 0 wins after release
    req = 4'b1111;
    tick();
    chk("s5_gnt", 64'(gnt), 64'h4);
    rst_w = 1'b0;
    #1;
    chk("s5_we_in_reset", 64'(wrt_enable), 64'h0);
    chk("s5_ack_in_reset", 64'(ack), 64'h0);
    tick();
    chk("s5_rst_gnt", 64'(gnt), 64'h0);
    chk("s5_rst_busy", 64'(busy), 64'h0);
    chk("s5_rst_wdata", 64'(wdata), 64'h0);
    push_n(0, EBL);
    rst_w = 1'b1;
    tick();
    chk("s5_post_rst_gnt", 64'(gnt), 64'h1);
    wait_empty("s5");
    req = 4'b0000;

    // All requesting: order 0,1,2,3,0 with a bubble after each burst
    rst_w = 1'b0;
    tick();
    rst_w = 1'b1;
    req   = 4'b1111;
    for (int b = 0; b < 5; b++) push_n(order[b], EBL);
    for (int b = 0; b < 5; b++) begin
      tick();
      chk("s6_gnt", 64'(gnt), 64'(4'b0001 << order[b]));
      repeat (EBL - 1) tick();
      tick();
      chk("s6_bubble", 64'(busy), 64'h0);
    end
    req = 4'b0000;
    tick();
    chk("s6_sb_empty", 64'(sb.size()), 64'h0);
    chk("s6_end_busy", 64'(busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter width, default 32, data word width in bits; SHALL match the FIFO write data width.
REQ-002 Parameter nreq, default 4, number of requesters; legal range 2..16.
REQ-003 Parameter burst_len, default 8, maximum words per grant; legal range 1..256.
REQ-004 Port clk_w  input  1  write-domain clock; one clock, all logic on its rising edge.
REQ-005 Port rst_w  input  1  reset; synchronous, active-low.
REQ-006 Port req  input  nreq  per-requester request; bit i high = requester i has a word on its data slice.
REQ-007 Port wdata_in  input  nreq*width  requester data; slice i is [i*width +: width].
REQ-008 Port full  input  1  FIFO full flag from the write-pointer/full logic.
REQ-009 Port wrt_enable  output  1  write request to the FIFO write side.
REQ-010 Port wdata  output  width  data to the FIFO, the granted requester's slice.
REQ-011 Port gnt  output  nreq  registered one-hot grant; all zero when no grant.
REQ-012 Port ack  output  nreq  per-requester word-accepted strobe, one cycle per word.
REQ-013 Port busy  output  1  high while in XFER.

Function
REQ-014 FSM SHALL have two states: IDLE and XFER.
REQ-015 IDLE: with any req bit high, SHALL pick the winner round-robin, searching from (last+1) mod nreq upward; gnt and last SHALL load the winner on the next edge; state -> XFER.
REQ-016 IDLE: wrt_enable, ack and gnt SHALL be 0; grant latency from req to gnt SHALL be exactly 1 cycle.
REQ-017 XFER, grant g: wrt_enable SHALL be combinational req[g] & ~full; ack SHALL be one-hot at g when wrt_enable is high, else 0.
REQ-018 wdata SHALL equal slice g of wdata_in while gnt is nonzero, else 0.
REQ-019 A word SHALL count as accepted only on a cycle with wrt_enable high; requesters SHALL hold data stable until ack.
REQ-020 full high in XFER SHALL stall: no write, no ack, the grant is held, and the burst count does not change.
REQ-021 A burst counter SHALL clear on entry to XFER and increment on each accepted word; its width is clog2(burst_len)+1 bits.
REQ-022 XFER -> IDLE, with gnt cleared on the same edge, when req[g] is low, or when a word is accepted and the counter then reaches burst_len.
REQ-023 After XFER -> IDLE, IDLE SHALL spend at least one cycle before the next grant, giving a one-cycle bubble between grants.
REQ-024 Requests arriving mid-burst SHALL NOT preempt the current grant.
REQ-025 With exactly one requester active, it SHALL be re-granted after every bubble; there SHALL be no starvation with multiple requesters.

Reset
REQ-026 When rst_w is low at a clk_w edge: state SHALL become IDLE; gnt = 0; burst counter = 0; last = nreq-1, so requester 0 has first priority.
REQ-027 During and after reset: wrt_enable = 0, ack = 0, busy = 0, wdata = 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst; no write SHALL occur on the reset edge.

Configuration
REQ-029 The feature SHALL be controlled by the macro FIFO_WR_ARB_BURST_EN.
REQ-030 With FIFO_WR_ARB_BURST_EN defined, bursts SHALL end per REQ-022 using burst_len.
REQ-031 With FIFO_WR_ARB_BURST_EN undefined, the effective burst length SHALL be 1: XFER ends after every accepted word, burst_len is ignored and the burst counter is absent.

Verification
REQ-032 After reset, req=4'b0101 and full=0 -> gnt=0001 one cycle later; the next grant is 0100 and then 0001, alternating.
REQ-033 Macro defined, burst_len=8, req[2] held high, full=0 -> 8 consecutive acks on requester 2, then busy=0 for 1 cycle, then gnt=0100 again.
REQ-034 Mid-burst with 3 words written, full=1 for 5 cycles -> wrt_enable=0 and gnt held; after full=0, exactly 5 more words are accepted.
REQ-035 req[1] drops after 2 accepted words -> IDLE on the next edge, and the counter restarts at 0 on the next grant.
REQ-036 rst_w=0 in XFER with req=1111 -> the next cycle has gnt=0, wrt_enable=0, and gnt=0001 one cycle after reset releases.
REQ-037 Macro undefined, req=4'b1111 -> single-word grants in the order 0,1,2,3,0, each followed by a one-cycle bubble.
